// File: rtl/shift_count_sched.sv
// shift_count_sched: run-length scheduler for a 2-bit add counter and a wide
// 2-bit-per-step shift register. Runs commanded bursts of exactly len steps,
// with pause, abort and clear control, and pulses done when a burst completes.
//
// Ports:
//   clk, rst_n      rising-edge clock, synchronous active-low reset
//   start, len      burst request and length in steps (sampled in IDLE only)
//   pause           hold the datapath while running
//   abort           end a burst early, without a done pulse
//   clear           zero the datapath (honoured in IDLE only)
//   busy, done      decoded from state: busy in RUN/DONE, done in DONE
//   step            high in any cycle where the datapath advances
//   counter_add     add counter
//   counter_shift   shift register, two ones shifted in per step
//   full            counter_shift is all ones
//   remain          steps still to execute
//   wrap_cnt        count of counter_add wraps from max to 0
module shift_count_sched #(
    parameter int unsigned SHIFT_W = 127,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned WRAP_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
    input  logic               pause,
    input  logic               abort,
    input  logic               clear,
    output logic               busy,
    output logic               done,
    output logic               step,
    output logic [CNT_W-1:0]   counter_add,
    output logic [SHIFT_W-1:0] counter_shift,
    output logic               full,
    output logic [LEN_W-1:0]   remain,
    output logic [WRAP_W-1:0]  wrap_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    logic [SHIFT_W-1:0] shift_next;

    // Next shift value: shift left by two and fill with ones.
    if (SHIFT_W > 2) begin : g_wide
        assign shift_next = {counter_shift[SHIFT_W-3:0], 2'b11};
    end else begin : g_narrow
        assign shift_next = '1;
    end

    // Status decode; abort outranks pause, and both suppress the step.
    assign step = (state == RUN) && !abort && !pause;
    assign busy = (state == RUN) || (state == DONE);
    assign done = (state == DONE);
    assign full = &counter_shift;

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            counter_add   <= '0;
            counter_shift <= '0;
            remain        <= '0;
            wrap_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            remain <= len;
                            state  <= RUN;
                        end else begin
                            state  <= DONE;
                        end
                    end else if (clear) begin
                        counter_add   <= '0;
                        counter_shift <= '0;
                        wrap_cnt      <= '0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        remain <= '0;
                        state  <= IDLE;
                    end else if (!pause) begin
                        counter_add   <= counter_add + CNT_W'(1);
                        counter_shift <= shift_next;
                        remain        <= remain - LEN_W'(1);
                        if (&counter_add) begin
                            wrap_cnt <= wrap_cnt + WRAP_W'(1);
                        end
                        if (remain == LEN_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_count_sched.sv
// Self-checking bench for shift_count_sched: bursts, wraps, fill-to-full,
// pause/abort, zero-length bursts, clear, ignored start and mid-burst reset.
module tb_shift_count_sched;

    localparam int unsigned SW = 127;
    localparam int unsigned CW = 2;
    localparam int unsigned LW = 16;
    localparam int unsigned WW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic          pause = 1'b0;
    logic          abort = 1'b0;
    logic          clear = 1'b0;
    logic          busy, done, step, full;
    logic [CW-1:0] counter_add;
    logic [SW-1:0] counter_shift;
    logic [LW-1:0] remain;
    logic [WW-1:0] wrap_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int            steps;
        int            busy_cyc;
        int            dones;
        logic [CW-1:0] add;
        logic [SW-1:0] shift;
        logic [WW-1:0] wrap;
    } exp_t;

    exp_t sb[$];

    // Reference datapath state
    logic [CW-1:0] m_add = '0;
    logic [SW-1:0] m_shift = '0;
    logic [WW-1:0] m_wrap = '0;

    shift_count_sched #(.SHIFT_W(SW), .CNT_W(CW), .LEN_W(LW), .WRAP_W(WW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .pause(pause),
        .abort(abort), .clear(clear), .busy(busy), .done(done), .step(step),
        .counter_add(counter_add), .counter_shift(counter_shift), .full(full),
        .remain(remain), .wrap_cnt(wrap_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_steps(input int n);
        for (int i = 0; i < n; i++) begin
            if (m_add == 2'b11) m_wrap = m_wrap + 8'd1;
            m_add   = m_add + 2'd1;
            m_shift = {m_shift[SW-3:0], 2'b11};
        end
    endtask

    // Drive one burst from IDLE; expectations are queued at start and
    // compared once the DUT drops busy.
    task automatic run_burst(input int l, input int pf, input int pt,
                             input int ab_rem, output int first_full);
        exp_t e;
        int rc = 0, bc = 0, sc = 0, dc = 0, cyc;
        int np;
        bit was_paused = 0;
        bit timed_out = 1;
        logic [CW-1:0] pa = '0;
        logic [SW-1:0] ps = '0;
        np = (pf != 0) ? (pt - pf + 1) : 0;
        e.steps    = (ab_rem != 0) ? (l - ab_rem) : l;
        e.busy_cyc = e.steps + np + 1;
        e.dones    = (ab_rem != 0) ? 0 : 1;
        model_steps(e.steps);
        e.add = m_add; e.shift = m_shift; e.wrap = m_wrap;
        sb.push_back(e);
        first_full = -1;
        start = 1'b1; len = LW'(l);
        @(negedge clk);
        start = 1'b0; len = '0;
        for (cyc = 0; cyc < 300; cyc++) begin
            if (was_paused) begin
                checks++;
                if (counter_add !== pa || counter_shift !== ps) begin
                    errors++;
                    $display("FAIL pause_freeze: add=%0d exp %0d shift=%h exp %h",
                             counter_add, pa, counter_shift, ps);
                end
            end
            if (!busy) begin timed_out = 0; break; end
            if (full && first_full < 0) first_full = sc;
            pause = 1'b0; abort = 1'b0; was_paused = 0;
            if (!done) begin
                rc++;
                if (ab_rem != 0 && remain == LW'(ab_rem)) abort = 1'b1;
                else if (pf != 0 && rc >= pf && rc <= pt) pause = 1'b1;
            end
            #1;
            bc += int'(busy); sc += int'(step); dc += int'(done);
            if (pause) begin
                checks++;
                if (step !== 1'b0) begin
                    errors++;
                    $display("FAIL pause_step: step=%b exp 0", step);
                end
                pa = counter_add; ps = counter_shift; was_paused = 1;
            end
            @(negedge clk);
        end
        pause = 1'b0; abort = 1'b0;
        checks++;
        if (timed_out) begin
            errors++;
            $display("FAIL burst_timeout: busy still %b after 300 cycles exp 0", busy);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: size=0 exp 1");
        end else begin
            e = sb.pop_front();
            checks++;
            if (sc !== e.steps) begin errors++; $display("FAIL step_count: %0d exp %0d", sc, e.steps); end
            checks++;
            if (bc !== e.busy_cyc) begin errors++; $display("FAIL busy_cycles: %0d exp %0d", bc, e.busy_cyc); end
            checks++;
            if (dc !== e.dones) begin errors++; $display("FAIL done_pulses: %0d exp %0d", dc, e.dones); end
            checks++;
            if (counter_add !== e.add) begin errors++; $display("FAIL counter_add: %0d exp %0d", counter_add, e.add); end
            checks++;
            if (counter_shift !== e.shift) begin errors++; $display("FAIL counter_shift: %h exp %h", counter_shift, e.shift); end
            checks++;
            if (wrap_cnt !== e.wrap) begin errors++; $display("FAIL wrap_cnt: %0d exp %0d", wrap_cnt, e.wrap); end
            checks++;
            if (remain !== '0) begin errors++; $display("FAIL remain_end: %0d exp 0", remain); end
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_add = '0; m_shift = '0; m_wrap = '0;
        checks++;
        if ({counter_add, wrap_cnt, full} !== '0 || counter_shift !== '0) begin
            errors++;
            $display("FAIL clear: add=%0d wrap=%0d full=%b shift=%h exp all 0",
                     counter_add, wrap_cnt, full, counter_shift);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, step, full, counter_add, remain, wrap_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b done=%b step=%b full=%b add=%0d remain=%0d wrap=%0d exp 0",
                     busy, done, step, full, counter_add, remain, wrap_cnt);
        end
        checks++;
        if (counter_shift !== '0) begin
            errors++;
            $display("FAIL reset_shift: %h exp 0", counter_shift);
        end
        rst_n = 1'b1;
        m_add = '0; m_shift = '0; m_wrap = '0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int ff;
        run_burst(3, 0, 0, 0, ff);
        checks++;
        if (counter_shift !== SW'(64'h3F) || counter_add !== 2'd3) begin
            errors++;
            $display("FAIL basic_values: shift=%h add=%0d exp 3f/3", counter_shift, counter_add);
        end
    endtask

    task automatic test_wrap();
        int ff;
        do_clear();
        run_burst(5, 0, 0, 0, ff);
        checks++;
        if (counter_add !== 2'd1 || wrap_cnt !== 8'd1 || counter_shift !== SW'(64'h3FF) || full !== 1'b0) begin
            errors++;
            $display("FAIL wrap_values: add=%0d wrap=%0d shift=%h full=%b exp 1/1/3ff/0",
                     counter_add, wrap_cnt, counter_shift, full);
        end
    endtask

    task automatic test_full();
        int ff;
        do_clear();
        run_burst(64, 0, 0, 0, ff);
        checks++;
        if (ff !== 64) begin errors++; $display("FAIL full_rise_step: %0d exp 64", ff); end
        run_burst(2, 0, 0, 0, ff);
        checks++;
        if (full !== 1'b1 || counter_add !== 2'd2) begin
            errors++;
            $display("FAIL full_hold: full=%b add=%0d exp 1/2", full, counter_add);
        end
    endtask

    task automatic test_pause_abort();
        int ff;
        do_clear();
        run_burst(10, 3, 6, 0, ff);
        run_burst(10, 0, 0, 4, ff);
    endtask

    task automatic test_zero_len_clear();
        int ff;
        run_burst(0, 0, 0, 0, ff);
        do_clear();
    endtask

    task automatic test_ignored_start_and_reset();
        bit hit = 0;
        start = 1'b1; len = LW'(2);
        @(negedge clk);
        len = LW'(9);
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL len2_done: done=%b exp 1", done); end
        @(negedge clk);
        start = 1'b0; len = '0;
        model_steps(2);
        checks++;
        if (busy !== 1'b0 || counter_add !== m_add || remain !== '0) begin
            errors++;
            $display("FAIL start_ignored: busy=%b add=%0d remain=%0d exp 0/%0d/0",
                     busy, counter_add, remain, m_add);
        end
        start = 1'b1; len = LW'(20);
        @(negedge clk);
        start = 1'b0; len = '0;
        for (int i = 0; i < 40; i++) begin
            if (remain == LW'(7)) begin hit = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL remain7_reach: remain=%0d exp 7", remain); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, step, full, counter_add, remain, wrap_cnt} !== '0 || counter_shift !== '0) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b add=%0d remain=%0d wrap=%0d shift=%h exp 0",
                     busy, counter_add, remain, wrap_cnt, counter_shift);
        end
        rst_n = 1'b1;
        m_add = '0; m_shift = '0; m_wrap = '0;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_wrap();
        test_full();
        test_pause_abort();
        test_zero_len_clear();
        test_ignored_start_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
